// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative RV32M mul/div unit.
// Provides the funct3 op enum, FSM state enum and op-class helper functions.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } muldiv_state_e;

   function automatic logic is_div(muldiv_op_e op);
      logic [2:0] o;
      o = op;
      return o[2];
   endfunction

   function automatic logic is_rem(muldiv_op_e op);
      logic [2:0] o;
      o = op;
      return o[2] & o[1];
   endfunction

   function automatic logic is_signed_a(muldiv_op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(muldiv_op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Acceptance-time operand conditioning: magnitudes, result sign, special cases.
// Ports: op_i, a_i, b_i in; mag_a_o, mag_b_o, neg_o, special_o, special_val_o out.
module muldiv_operand_prep
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  muldiv_op_e            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] mag_a_o,
   output logic [DATA_WIDTH-1:0] mag_b_o,
   output logic                  neg_o,
   output logic                  special_o,
   output logic [DATA_WIDTH-1:0] special_val_o
);

   localparam logic [DATA_WIDTH-1:0] MIN_NEG =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic a_neg;
   logic b_neg;
   logic b_zero;
   logic ovf;

   always_comb begin
      a_neg   = is_signed_a(op_i) & a_i[DATA_WIDTH-1];
      b_neg   = is_signed_b(op_i) & b_i[DATA_WIDTH-1];
      mag_a_o = a_neg ? (~a_i + 1'b1) : a_i;
      mag_b_o = b_neg ? (~b_i + 1'b1) : b_i;
      // Remainder follows the dividend; everything else is sign-xor.
      neg_o   = is_rem(op_i) ? a_neg : (a_neg ^ b_neg);
      b_zero  = (b_i == '0);
      ovf     = is_div(op_i) & is_signed_b(op_i)
              & (a_i == MIN_NEG) & (b_i == '1);
      special_o     = is_div(op_i) & (b_zero | ovf);
      special_val_o = '0;
      if (b_zero) begin
         special_val_o = is_rem(op_i) ? a_i : '1;
      end else if (ovf) begin
         special_val_o = is_rem(op_i) ? '0 : MIN_NEG;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes and flush.
// Ports: clk, rst, in_valid/in_ready, op, SRCA, SRCB, flush,
//        out_valid/out_ready, ALUresult, busy.
module alu_muldiv
   import muldiv_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] SRCA,
   input  logic [DATA_WIDTH-1:0] SRCB,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUresult,
   output logic                  busy
);

   localparam int W = DATA_WIDTH;

   muldiv_state_e  state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   muldiv_op_e     op_q, op_d;
   logic           neg_q, neg_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [W-1:0]   res_q, res_d;

   muldiv_op_e     op_in;
   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;
   logic           prep_neg;
   logic           special;
   logic [W-1:0]   special_val;

   assign op_in = muldiv_op_e'(op);

   muldiv_operand_prep #(
      .DATA_WIDTH (W)
   ) u_prep (
      .op_i          (op_in),
      .a_i           (SRCA),
      .b_i           (SRCB),
      .mag_a_o       (mag_a),
      .mag_b_o       (mag_b),
      .neg_o         (prep_neg),
      .special_o     (special),
      .special_val_o (special_val)
   );

   // Multiply keeps {hi,lo} as {partial product, multiplier};
   // divide keeps {hi,lo} as {partial remainder, dividend/quotient}.
   logic [W:0]     sum;
   logic [W:0]     sh;
   logic [W-1:0]   diff;
   logic           ge;
   logic [W-1:0]   it_hi;
   logic [W-1:0]   it_lo;
   logic [2*W-1:0] prod;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   q_fix;
   logic [W-1:0]   r_fix;
   logic [W-1:0]   final_val;

   always_comb begin
      sum  = {1'b0, hi_q}
           + {1'b0, (lo_q[0] ? opnd_q : {W{1'b0}})};
      sh   = {hi_q, lo_q[W-1]};
      ge   = (sh >= {1'b0, opnd_q});
      // Result is below the divisor, so W bits suffice.
      diff = sh[W-1:0] - opnd_q;
      if (is_div(op_q)) begin
         it_hi = ge ? diff : sh[W-1:0];
         it_lo = {lo_q[W-2:0], ge};
      end else begin
         it_hi = sum[W:1];
         it_lo = {sum[0], lo_q[W-1:1]};
      end
      prod     = {it_hi, it_lo};
      prod_fix = neg_q ? (~prod + 1'b1) : prod;
      q_fix    = neg_q ? (~it_lo + 1'b1) : it_lo;
      r_fix    = neg_q ? (~it_hi + 1'b1) : it_hi;
      unique case (op_q)
         OP_MUL:    final_val = prod_fix[W-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  final_val = prod_fix[2*W-1:W];
         OP_DIV,
         OP_DIVU:   final_val = q_fix;
         OP_REM,
         OP_REMU:   final_val = r_fix;
         default:   final_val = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               op_d  = op_in;
               neg_d = prep_neg;
               cnt_d = CNT_WIDTH'(W - 1);
               hi_d  = '0;
               if (is_div(op_in)) begin
                  lo_d   = mag_a;
                  opnd_d = mag_b;
               end else begin
                  lo_d   = mag_b;
                  opnd_d = mag_a;
               end
               if (special) begin
                  res_d   = special_val;
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               hi_d  = it_hi;
               lo_d  = it_lo;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  res_d   = final_val;
                  cnt_d   = '0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (flush || out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_MUL;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign ALUresult = res_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: vector table, corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] SRCA;
   logic [31:0] SRCB;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUresult;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [31:0] MINN = 32'h8000_0000;

   alu_muldiv #(
      .DATA_WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .SRCA      (SRCA),
      .SRCB      (SRCB),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUresult (ALUresult),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       nm;
   } vec_t;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(
      input logic [2:0] o,
      input logic [31:0] a,
      input logic [31:0] b);
      longint sa, sb, sub;
      logic [63:0] ua, ub, p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      sub = longint'(ub);
      p   = '0;
      case (o)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * sub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINN && b == 32'hFFFF_FFFF) return MINN;
            p = sa / sb;
            return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == MINN && b == 32'hFFFF_FFFF) return 0;
            p = sa % sb;
            return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_lat(
      input logic [2:0] o,
      input logic [31:0] a,
      input logic [31:0] b);
      if (o[2] && b == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == MINN
          && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Waits for out_valid; lat counts edges with the acceptance edge as 1.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic accept(input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input string nm);
      @(negedge clk);
      chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
      op = o; SRCA = a; SRCB = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 3'($urandom); SRCA = $urandom; SRCB = $urandom;
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] o,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp,
                         input int exp_lat,
                         input string nm);
      int lat;
      accept(o, a, b, nm);
      wait_valid(lat);
      chk({nm, " lat"}, 32'(lat), 32'(exp_lat));
      chk({nm, " res"}, ALUresult, exp);
      drain();
   endtask

   vec_t vt[14];

   initial begin
      int lat;
      logic [31:0] held;
      rst = 1'b1; in_valid = 0; op = 0;
      SRCA = 0; SRCB = 0; flush = 0; out_ready = 0;

      vt[0]  = '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL"};
      vt[1]  = '{3'd1, MINN, MINN, 32'h4000_0000, 33, "MULH"};
      vt[2]  = '{3'd3, '1, '1, 32'hFFFF_FFFE, 33, "MULHU"};
      vt[3]  = '{3'd2, '1, '1, 32'hFFFF_FFFF, 33, "MULHSU"};
      vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV"};
      vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM"};
      vt[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU"};
      vt[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU"};
      vt[8]  = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIV0"};
      vt[9]  = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "DIVU0"};
      vt[10] = '{3'd6, 32'd5, 32'd0, 32'd5, 1, "REM0"};
      vt[11] = '{3'd7, 32'd5, 32'd0, 32'd5, 1, "REMU0"};
      vt[12] = '{3'd4, MINN, '1, MINN, 1, "DIVOVF"};
      vt[13] = '{3'd6, MINN, '1, 32'd0, 1, "REMOVF"};

      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst result", ALUresult, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vt[i]) begin
         run_op(vt[i].op, vt[i].a, vt[i].b,
                vt[i].exp, vt[i].lat, vt[i].nm);
      end

      // Backpressure then back-to-back request.
      accept(3'd3, '1, '1, "bp");
      wait_valid(lat);
      held = ALUresult;
      chk("bp res", held, 32'hFFFF_FFFE);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp hold res", ALUresult, held);
         chk("bp hold valid", 32'(out_valid), 32'd1);
         chk("bp in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      op = 3'd5; SRCA = 32'd100; SRCB = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp idle ready", 32'(in_ready), 32'd1);
      chk("bp idle valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b busy", 32'(busy), 32'd1);
      wait_valid(lat);
      chk("b2b lat", 32'(lat), 32'd33);
      chk("b2b res", ALUresult, 32'd14);
      drain();

      // Flush mid-CALC.
      accept(3'd4, 32'd1000, 32'd3, "fl");
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("fl valid", 32'(out_valid), 32'd0);
      chk("fl in_ready", 32'(in_ready), 32'd1);
      chk("fl busy", 32'(busy), 32'd0);
      lat = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      chk("fl no valid", 32'(lat), 32'd0);
      run_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "fl mul");

      // Flush and request together in IDLE.
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1;
      op = 3'd0; SRCA = 32'd2; SRCB = 32'd2;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flreq busy", 32'(busy), 32'd0);
      lat = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid || busy) lat++;
      end
      chk("flreq none", 32'(lat), 32'd0);

      // Reset mid-DIV.
      accept(3'd4, 32'd12345, 32'd7, "rs");
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rs in_ready", 32'(in_ready), 32'd1);
      chk("rs valid", 32'(out_valid), 32'd0);
      chk("rs result", ALUresult, 32'd0);
      chk("rs busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd5, 32'd9, 32'd3, 32'd3, 33, "rs divu");

      // Randomized ops against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         int sel;
         ro  = 3'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 0;
         if (sel == 1) begin ra = MINN; rb = '1; end
         if (sel == 2) begin
            ra = 32'($urandom_range(0, 50));
            rb = 32'($urandom_range(1, 9));
         end
         if (sel == 3) ra = -32'($urandom_range(0, 50));
         run_op(ro, ra, rb, ref_res(ro, ra, rb),
                ref_lat(ro, ra, rb), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative RV32M multiply/divide unit; sits beside the single-cycle integer ALU in the execute stage.
- Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, parametrised in data width.
- Multi-cycle: valid/ready handshake on input and output, with a flush input for pipeline kills.
- Radix-2 shift-add multiply; restoring divide on magnitudes, sign fixed up at the end.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and ≥ 4.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- op  in  3  RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SRCA  in  DATA_WIDTH  rs1 / dividend / multiplicand.
- SRCB  in  DATA_WIDTH  rs2 / divisor / multiplier.
- flush  in  1  abort the in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- ALUresult  out  DATA_WIDTH  result.
- busy  out  1  state != IDLE.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, ALUresult=0, counter=0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid && !flush, latch op and operands.
    - Go to DONE if the request is a special case, otherwise go to CALC.
  - CALC:
    - Exactly DATA_WIDTH iterations, one per cycle; counter runs DATA_WIDTH-1 down to 0.
    - Sign fix-up is applied on the final iteration edge; then go to DONE.
  - DONE:
    - out_valid=1; ALUresult is held stable.
    - When out_ready=1, go to IDLE.
    - The next request can be accepted only on the cycle after the output handshake (in_ready=0 while in DONE).
- Latency, measured from the acceptance edge:
  - Normal ops: out_valid rises after DATA_WIDTH+1 edges.
  - Special cases: out_valid rises after 1 edge.
- Multiply:
  - Operands are converted to magnitudes per op: MULH signed×signed; MULHSU SRCA signed, SRCB unsigned; MULHU and MUL unsigned. MUL's low half is sign-agnostic.
  - Builds a 2·DATA_WIDTH product.
  - Product is negated if exactly one signed operand is negative.
  - MUL returns the low half; MULH* return the high half.
- Divide:
  - Restoring algorithm on magnitudes.
  - Quotient rounds toward zero.
  - Quotient is negative iff signed and dividend sign ≠ divisor sign.
  - Remainder takes the sign of the dividend.
- Special cases (no CALC):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → SRCA.
  - Signed overflow (SRCA = most-negative, SRCB = −1, DIV/REM only): DIV → most-negative; REM → 0.
- flush:
  - In CALC or DONE: go to IDLE on the next edge and discard the result; out_valid is 0 from that edge.
  - In IDLE: has priority over in_valid; the request is not accepted.
- Reset mid-operation returns every output to its reset value on the next edge.
- Inputs are sampled only at acceptance; changes to SRCA/SRCB/op afterwards have no effect.
- out_valid && !out_ready: ALUresult and out_valid stay unchanged indefinitely.

Decomposition:
- Shared package muldiv_pkg:
  - muldiv_op_e enum matching the funct3 encoding.
  - muldiv_state_e {IDLE, CALC, DONE}.
  - Helper functions is_div(op) and is_signed_a/b(op).
- Sub-module muldiv_operand_prep (combinational), used at acceptance:
  - Computes operand magnitudes, result-negate flag, and special-case flag/value.
- Iteration datapath and FSM remain in alu_muldiv.

Test Plan:
- All at DATA_WIDTH=32.
- MUL 7×0xFFFFFFFD → 0xFFFFFFEB. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. Each: out_valid exactly 33 edges after acceptance.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divisor 0 with SRCA=5: DIV → 0xFFFFFFFF, DIVU → 0xFFFFFFFF, REM → 5, REMU → 5. Overflow 0x80000000/0xFFFFFFFF: DIV → 0x80000000, REM → 0. All with out_valid 1 edge after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → ALUresult/out_valid stable, in_ready=0. Assert out_ready → IDLE next edge. A back-to-back request is accepted the following cycle and is correct.
- flush at CALC iteration 10 → out_valid never rises; in_ready=1 next cycle. Then MUL 3×4 → 12. flush and in_valid together in IDLE → request not taken.
- rst asserted mid-DIV → next edge: in_ready=1, out_valid=0, ALUresult=0, busy=0. A subsequent DIVU 9/3 → 3.
